// File: rtl/router_sync_multi.sv
// FSM-to-FIFO synchronizer for NUM_PORTS output FIFOs: address latch, write steering,
// full-flag mux, registered valid_out and per-port read-timeout flush.
// Optional status block (timeout_sticky / status_clr) enabled by macro ROUTER_SYNC_STATUS_EN.
module router_sync_multi #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30,
    parameter int CNT_W     = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 detect_add,
    input  logic                 write_enb_reg,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] read_enb,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] full,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic                 addr_err,
    output logic [NUM_PORTS-1:0] valid_out,
    output logic [NUM_PORTS-1:0] soft_reset
`ifdef ROUTER_SYNC_STATUS_EN
    ,
    input  logic                 status_clr,
    output logic [NUM_PORTS-1:0] timeout_sticky
`endif
);

    // FLUSH is the only state with bit 1 set, so soft_reset is a direct flop bit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FLUSH = 2'b10
    } port_state_t;

    localparam logic [ADDR_W:0]  NUM_PORTS_L = (ADDR_W+1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_TERM    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0]    addr_reg_r;
    logic                 addr_ok_r;
    logic                 addr_ok_s;
    logic [NUM_PORTS-1:0] idle_s;
    logic [CNT_W-1:0]     cnt_r   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_s   [NUM_PORTS];
    port_state_t          state_r [NUM_PORTS];
    port_state_t          state_s [NUM_PORTS];

    // Range check of the incoming destination address.
    always_comb begin
        addr_ok_s = ({1'b0, data_in} < NUM_PORTS_L);
    end

    // Address latch on header strobe; addr_err tracks the validity of the latched address.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_reg_r <= {ADDR_W{1'b0}};
            addr_ok_r  <= 1'b0;
            addr_err   <= 1'b0;
        end else if (detect_add) begin
            addr_reg_r <= data_in;
            addr_ok_r  <= addr_ok_s;
            addr_err   <= ~addr_ok_s;
        end else begin
            addr_reg_r <= addr_reg_r;
            addr_ok_r  <= addr_ok_r;
            addr_err   <= addr_err;
        end
    end

    // Write steering and full-flag mux from the latched (old) address.
    always_comb begin
        write_enb = {NUM_PORTS{1'b0}};
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_ok_r && (addr_reg_r == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end else begin
                write_enb[i] = 1'b0;
            end
        end
    end

    // Registered per-port data-available flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_out <= {NUM_PORTS{1'b0}};
        end else begin
            valid_out <= ~empty;
        end
    end

    // Per-port timeout next-state: count stalled cycles, flush at the terminal count.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_s[i]   = cnt_r[i];
            state_s[i] = state_r[i];
            idle_s[i]  = valid_out[i] & ~read_enb[i];
            if (!idle_s[i]) begin
                cnt_s[i]   = CNT_ZERO;
                state_s[i] = ST_IDLE;
            end else if (cnt_r[i] == CNT_TERM) begin
                cnt_s[i]   = CNT_ZERO;
                state_s[i] = ST_FLUSH;
            end else begin
                cnt_s[i]   = cnt_r[i] + CNT_ONE;
                state_s[i] = ST_WAIT;
            end
        end
    end

    // Per-port timeout state and counter registers.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!reset_n) begin
                cnt_r[i]   <= CNT_ZERO;
                state_r[i] <= ST_IDLE;
            end else begin
                cnt_r[i]   <= cnt_s[i];
                state_r[i] <= state_s[i];
            end
        end
    end

    // Flush pulse taken straight from the FLUSH state bit.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            soft_reset[i] = state_r[i][1];
        end
    end

`ifdef ROUTER_SYNC_STATUS_EN
    // Sticky timeout record; a new flush wins over a coincident clear.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!reset_n) begin
                timeout_sticky[i] <= 1'b0;
            end else if (state_s[i] == ST_FLUSH) begin
                timeout_sticky[i] <= 1'b1;
            end else if (status_clr) begin
                timeout_sticky[i] <= 1'b0;
            end else begin
                timeout_sticky[i] <= timeout_sticky[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_sync_multi.sv
// Scoreboard bench for router_sync_multi: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_router_sync_multi;

    logic       clock;
    logic       reset_n;
    logic       detect_add;
    logic       write_enb_reg;
    logic [1:0] data_in;
    logic [2:0] read_enb;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       addr_err;
    logic [2:0] valid_out;
    logic [2:0] soft_reset;
`ifdef ROUTER_SYNC_STATUS_EN
    logic       status_clr;
    logic [2:0] timeout_sticky;
`endif

    router_sync_multi #(
        .NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(5)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .detect_add    (detect_add),
        .write_enb_reg (write_enb_reg),
        .data_in       (data_in),
        .read_enb      (read_enb),
        .empty         (empty),
        .full          (full),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .addr_err      (addr_err),
        .valid_out     (valid_out),
        .soft_reset    (soft_reset)
`ifdef ROUTER_SYNC_STATUS_EN
        ,
        .status_clr    (status_clr),
        .timeout_sticky(timeout_sticky)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [5:0] mask;   // 0 we, 1 ff, 2 ae, 3 vo, 4 sr, 5 st
        logic [2:0] we;
        logic       ff;
        logic       ae;
        logic [2:0] vo;
        logic [2:0] sr;
        logic [2:0] st;
    } exp_t;

    localparam logic [5:0] M_ALL = 6'h3f;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   failed    = 0;

    task automatic push(input string tag, input logic [5:0] mask, input logic [2:0] we,
                        input logic ff, input logic ae, input logic [2:0] vo,
                        input logic [2:0] sr, input logic [2:0] st);
        exp_t e;
        e.tag = tag; e.mask = mask; e.we = we; e.ff = ff; e.ae = ae;
        e.vo = vo; e.sr = sr; e.st = st;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.mask[0]) chk(e.tag, "write_enb",  16'(write_enb),  16'(e.we));
            if (e.mask[1]) chk(e.tag, "fifo_full",  16'(fifo_full),  16'(e.ff));
            if (e.mask[2]) chk(e.tag, "addr_err",   16'(addr_err),   16'(e.ae));
            if (e.mask[3]) chk(e.tag, "valid_out",  16'(valid_out),  16'(e.vo));
            if (e.mask[4]) chk(e.tag, "soft_reset", 16'(soft_reset), 16'(e.sr));
`ifdef ROUTER_SYNC_STATUS_EN
            if (e.mask[5]) chk(e.tag, "sticky", 16'(timeout_sticky), 16'(e.st));
`endif
        end
    end

    initial begin
        // 1: reset with arbitrary inputs
        reset_n = 1'b0; detect_add = 1'b1; write_enb_reg = 1'b1; data_in = 2'd1;
        read_enb = 3'b000; empty = 3'b000; full = 3'b111;
`ifdef ROUTER_SYNC_STATUS_EN
        status_clr = 1'b0;
`endif
        tick();
        push("rst1", M_ALL, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        push("rst2", M_ALL, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        reset_n = 1'b1; detect_add = 1'b0; write_enb_reg = 1'b0; data_in = 2'd0;
        empty = 3'b111; full = 3'b000;
        tick();

        // 2: header to port 2, write burst with full[2] toggling
        detect_add = 1'b1; data_in = 2'd2;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        for (int j = 0; j < 4; j++) begin
            full = (j % 2 == 1) ? 3'b100 : 3'b011;
            push("p2_wr", M_ALL, 3'b100, (j % 2 == 1), 1'b0, 3'b000, 3'b000, 3'b000);
            tick();
        end
        write_enb_reg = 1'b0; full = 3'b000;
        push("p2_end", M_ALL, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();

        // 3: out-of-range address, then headers coincident with writes
        detect_add = 1'b1; data_in = 2'd3;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
        push("bad_addr", M_ALL, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000);
        tick();
        detect_add = 1'b1; data_in = 2'd0;
        push("hdr_old_bad", M_ALL, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000);
        tick();
        detect_add = 1'b0; full = 3'b001;
        push("p0_wr", M_ALL, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        detect_add = 1'b1; data_in = 2'd1; full = 3'b110;
        push("hdr_old_p0", M_ALL, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        detect_add = 1'b0; full = 3'b010;
        push("p1_wr_a", M_ALL, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        full = 3'b101;
        push("p1_wr_b", M_ALL, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        write_enb_reg = 1'b0; full = 3'b000;
        tick();

        // 4: port 1 stalled: valid after 1 cycle, pulse after 30 idle edges, repeating
        empty = 3'b101; read_enb = 3'b000;
        push("p1_pre", M_ALL, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        for (int n = 1; n <= 65; n++) begin
            push("p1_stall", M_ALL, 3'b000, 1'b0, 1'b0, 3'b010,
                 (n == 31 || n == 61) ? 3'b010 : 3'b000,
                 (n >= 31) ? 3'b010 : 3'b000);
            tick();
        end
        read_enb = 3'b111; empty = 3'b111;
        tick();
        tick();
        read_enb = 3'b000;

        // 5: port 0 read on the terminal count: no pulse, count restarts
        empty = 3'b110;
        tick();
        for (int n = 1; n <= 29; n++) begin
            push("p0_stall", 6'h38, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 3'b010);
            tick();
        end
        read_enb = 3'b001;
        push("p0_e30", 6'h38, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 3'b010);
        tick();
        read_enb = 3'b000;
        push("p0_rd_term", 6'h38, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 3'b010);
        tick();
        for (int n = 32; n <= 62; n++) begin
            push("p0_restart", 6'h38, 3'b000, 1'b0, 1'b0, 3'b001,
                 (n == 61) ? 3'b001 : 3'b000,
                 (n >= 61) ? 3'b011 : 3'b010);
            tick();
        end
        read_enb = 3'b111; empty = 3'b111;
        tick();
        tick();
        read_enb = 3'b000;

        // 6: all ports stalled together; sticky clear and set-wins-over-clear
`ifdef ROUTER_SYNC_STATUS_EN
        status_clr = 1'b1;
`endif
        tick();
`ifdef ROUTER_SYNC_STATUS_EN
        status_clr = 1'b0;
`endif
        push("all_pre", M_ALL, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000);
        tick();
        empty = 3'b000;
        tick();
        for (int n = 1; n <= 62; n++) begin
            push("all_stall", 6'h38, 3'b000, 1'b0, 1'b0, 3'b111,
                 (n == 31 || n == 61) ? 3'b111 : 3'b000,
                 ((n >= 31 && n < 46) || n >= 61) ? 3'b111 : 3'b000);
`ifdef ROUTER_SYNC_STATUS_EN
            status_clr = (n == 45 || n == 60);
`endif
            tick();
        end
`ifdef ROUTER_SYNC_STATUS_EN
        status_clr = 1'b0;
`endif

        for (int k = 0; k < 5 && sb_q.size() != 0; k++) tick();
        tests_run++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/router_sync_multi.md
Name: router_sync_multi

Overview:
Parametrised successor to the router's FSM-to-FIFO synchronizer, sitting between the router FSM, the input register block and NUM_PORTS output FIFOs.
- Latches the destination address on each header and steers the write enable to the addressed FIFO.
- Muxes back that FIFO's full flag.
- Generates per-port registered valid_out.
- Runs one independent read-timeout counter per port, which issues a one-cycle soft_reset when the reader stalls.

Parameters:
NUM_PORTS, 3, number of output FIFOs/ports (2..16).
ADDR_W, 2, width of address field on data_in; must satisfy 2**ADDR_W >= NUM_PORTS.
TIMEOUT, 30, consecutive unread valid cycles before soft_reset fires (>= 2).
CNT_W, 5, timeout counter width; must satisfy TIMEOUT <= 2**CNT_W - 1.

Ports:
clock  in  1  single clock; all state updates on rising edge.
reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock.
detect_add  in  1  FSM strobe: header present, data_in holds destination address.
write_enb_reg  in  1  FSM request to write current byte to addressed FIFO.
data_in  in  ADDR_W  destination address field.
read_enb  in  NUM_PORTS  per-port reader read strobe.
empty  in  NUM_PORTS  per-FIFO empty flag.
full  in  NUM_PORTS  per-FIFO full flag.
write_enb  out  NUM_PORTS  one-hot (or zero) FIFO write enable.
fifo_full  out  1  full flag of currently addressed FIFO.
addr_err  out  1  latched address is >= NUM_PORTS.
valid_out  out  NUM_PORTS  registered ~empty per port.
soft_reset  out  NUM_PORTS  one-cycle per-port FIFO flush pulse.

Behaviour:
- Reset (reset_n=0 at posedge):
  - addr_reg=0, addr_ok=0, all counters=0.
  - valid_out=0, soft_reset=0, addr_err=0.
  - Reset applied mid-packet or mid-count takes effect that edge; no partial state survives.
- Address latch: detect_add=1 at posedge loads addr_reg<=data_in and addr_ok<=(data_in<NUM_PORTS). Otherwise both hold. New address is effective from the following cycle.
- addr_err: registered, equals ~addr_ok after the latch.
- write_enb (combinational from registered state): write_enb[i] = write_enb_reg & addr_ok & (addr_reg==i).
  - At most one bit high.
  - Invalid address gives all zero, so the packet is dropped.
- Simultaneous detect_add and write_enb_reg: the write goes to the old addr_reg; the latch updates at that same edge.
- fifo_full (combinational): full[addr_reg] when addr_ok, else 0.
- valid_out[i] <= ~empty[i] every posedge; latency 1 cycle from empty.
- Timeout counter, per port i, fully independent; no priority between ports:
  - idle_i = valid_out[i] & ~read_enb[i].
  - When idle_i=0: cnt_i<=0, soft_reset[i]<=0.
  - When idle_i=1 and cnt_i<TIMEOUT-1: cnt_i<=cnt_i+1, soft_reset[i]<=0.
  - When idle_i=1 and cnt_i==TIMEOUT-1: soft_reset[i]<=1, cnt_i<=0.
  - Result: soft_reset[i] is high exactly one cycle, on the cycle after the TIMEOUT-th consecutive idle edge. If the reader stays stalled, it repeats every TIMEOUT cycles.
  - The counter never wraps; it cannot exceed TIMEOUT-1.
- read_enb asserted on any cycle clears the count that edge, including on the terminal count (no pulse).
- Port states: IDLE (valid_out=0), WAIT (counting), FLUSH (soft_reset pulse). FLUSH returns to IDLE or WAIT per idle_i next cycle.

Optional Feature:
Macro ROUTER_SYNC_STATUS_EN.
- Defined:
  - Adds input status_clr (1) and output timeout_sticky (NUM_PORTS).
  - timeout_sticky[i] sets at the same edge soft_reset[i] rises.
  - Cleared by status_clr=1 at posedge; set wins over a simultaneous clear.
  - Reset value 0.
- Undefined: both ports and the sticky logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with arbitrary inputs, reset_n=0 for 2 cycles -> all outputs 0, write_enb=0 even with write_enb_reg=1.
2. detect_add with data_in=2, then write_enb_reg=1 for 4 cycles -> write_enb=3'b100 on those cycles, fifo_full follows full[2]; toggle full[2] -> fifo_full tracks it combinationally.
3. data_in=3 with NUM_PORTS=3 -> addr_err=1 next cycle, write_enb=0, fifo_full=0; next header to port 0 clears addr_err.
4. empty[1]=0, read_enb[1]=0 held -> valid_out[1]=1 after 1 cycle; soft_reset[1] high exactly one cycle after 30 idle edges, repeating every 30; ports 0/2 unaffected.
5. Stall port 0 for 29 cycles, read_enb[0]=1 on cycle 30 -> no soft_reset; count restarts from 0. Also run simultaneous stalls on all three ports -> three concurrent pulses.
6. With ROUTER_SYNC_STATUS_EN: after a port-2 timeout, timeout_sticky=3'b100 held until status_clr. status_clr coincident with a new pulse -> sticky stays 1.
